vdc_cpu_port: RTL and testbench

- CPU-side write/read front end of the Laser 500 video subsystem; the opposite end of the video fetch path.
- Accepts Z80 VRAM writes and reads and VDC I/O register writes.
- Posts VRAM writes into a small FIFO and drains them into the shared video RAM in cycles the video fetcher does not claim.
- Holds the VDC mode/colour registers the display engine consumes.

---
 rtl/vdc_cpu_port.sv | 191 +++++++++++++++++++
 tb/tb_vdc_cpu_port.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdc_cpu_port.sv
// Laser 500 VDC CPU port: posted VRAM write FIFO, CPU read path, video-priority RAM arbiter and VDC registers.
// Optional vertical-blank interrupt is compiled in when VDC_IRQ_EN is defined.
module vdc_cpu_port #(
  parameter int ADDR_W     = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              F14M,
  input  logic              reset,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_data,
  output logic              cpu_wait,
  output logic [7:0]        cpu_rd_data,
  output logic              cpu_rd_valid,
  output logic              cpu_overrun,
  input  logic              io_wr,
  input  logic [1:0]        io_addr,
  input  logic [7:0]        io_data,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_data,
  output logic              vid_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic              vsync,
  output logic              irq,
  output logic              gfx_en,
  output logic [2:0]        gfx_mode,
  output logic              text80,
  output logic [3:0]        fg,
  output logic [3:0]        bg,
  output logic [3:0]        border
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE_R, RD_PEND, RD_DATA} rd_state_t;

  rd_state_t         rd_state_reg, rd_state_next;
  logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
  logic [7:0]        fifo_data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [7:0]        rd_hold_reg, vid_hold_reg;
  logic              vid_valid_reg, overrun_reg;
  logic              gfx_en_reg, text80_reg;
  logic [2:0]        gfx_mode_reg;
  logic [3:0]        fg_reg, bg_reg, border_reg;

  logic fifo_full, fifo_empty, wr_acc, rd_acc, pop, rd_issue;

  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  // RD_DATA is the completion cycle, so a new strobe may be taken while the data is returned.
  assign cpu_wait   = fifo_full || (rd_state_reg == RD_PEND);
  assign wr_acc     = cpu_wr && !cpu_wait;
  assign rd_acc     = cpu_rd && !cpu_wr && !cpu_wait;

  // One RAM operation per cycle: video fetch, then FIFO drain, then the pending CPU read.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    pop       = 1'b0;
    rd_issue  = 1'b0;
    if (!reset) begin
      if (vid_req) begin
        ram_addr = vid_addr;
      end else if (!fifo_empty) begin
        ram_addr  = fifo_addr_mem[rd_ptr_reg];
        ram_wdata = fifo_data_mem[rd_ptr_reg];
        ram_we    = 1'b1;
        pop       = 1'b1;
      end else if (rd_state_reg == RD_PEND) begin
        ram_addr = rd_addr_reg;
        rd_issue = 1'b1;
      end
    end
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    cpu_rd_valid  = 1'b0;
    cpu_rd_data   = rd_hold_reg;
    case (rd_state_reg)
      IDLE_R:  if (rd_acc) rd_state_next = RD_PEND;
      RD_PEND: if (rd_issue) rd_state_next = RD_DATA;
      RD_DATA: begin
        cpu_rd_valid  = !reset;
        cpu_rd_data   = ram_rdata;
        rd_state_next = rd_acc ? RD_PEND : IDLE_R;
      end
      default: rd_state_next = IDLE_R;
    endcase
  end

  assign vid_valid = vid_valid_reg && !reset;
  assign vid_data  = vid_valid_reg ? ram_rdata : vid_hold_reg;

  always_ff @(posedge F14M) begin
    if (reset) begin
      rd_state_reg  <= IDLE_R;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      rd_addr_reg   <= '0;
      rd_hold_reg   <= '0;
      vid_hold_reg  <= '0;
      vid_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      gfx_en_reg    <= 1'b0;
      gfx_mode_reg  <= 3'd5;
      text80_reg    <= 1'b0;
      fg_reg        <= 4'd15;
      bg_reg        <= 4'd1;
      border_reg    <= 4'd9;
    end else begin
      rd_state_reg  <= rd_state_next;
      vid_valid_reg <= vid_req;
      if (wr_acc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(wr_acc) - CNT_W'(pop);
      if (rd_acc) rd_addr_reg <= cpu_addr;
      if (rd_state_reg == RD_DATA) rd_hold_reg <= ram_rdata;
      if (vid_valid_reg) vid_hold_reg <= ram_rdata;
      if (((cpu_wr || cpu_rd) && cpu_wait) || (cpu_wr && cpu_rd)) overrun_reg <= 1'b1;
      if (io_wr) begin
        case (io_addr)
          2'd0: begin
            gfx_en_reg   <= io_data[3];
            gfx_mode_reg <= io_data[2:0];
            text80_reg   <= io_data[4];
          end
          2'd1: begin
            fg_reg <= io_data[7:4];
            bg_reg <= io_data[3:0];
          end
          2'd2: border_reg <= io_data[3:0];
          default: ;
        endcase
      end
    end
  end

  // FIFO storage carries no reset; the pointers alone define what is valid.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
    always_ff @(posedge F14M) begin
      if (wr_acc && (wr_ptr_reg == PTR_W'(gi))) begin
        fifo_addr_mem[gi] <= cpu_addr;
        fifo_data_mem[gi] <= cpu_data;
      end
    end
  end

  assign cpu_overrun = overrun_reg;
  assign gfx_en      = gfx_en_reg;
  assign gfx_mode    = gfx_mode_reg;
  assign text80      = text80_reg;
  assign fg          = fg_reg;
  assign bg          = bg_reg;
  assign border      = border_reg;

`ifdef VDC_IRQ_EN
  logic vsync_r_reg, vsync_rr_reg, irq_reg;

  always_ff @(posedge F14M) begin
    if (reset) begin
      vsync_r_reg  <= 1'b0;
      vsync_rr_reg <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      vsync_r_reg  <= vsync;
      vsync_rr_reg <= vsync_r_reg;
      if (vsync_rr_reg && !vsync_r_reg) irq_reg <= 1'b1;
      else if (io_wr && (io_addr == 2'd3)) irq_reg <= 1'b0;
    end
  end

  assign irq = irq_reg;
`else
  logic unused_vsync;
  assign unused_vsync = vsync;
  assign irq          = 1'b0;
`endif

endmodule

// File: tb/tb_vdc_cpu_port.sv
// Self-checking bench for vdc_cpu_port: directed steps plus randomized traffic against a queue-based model.
module tb_vdc_cpu_port;
  localparam int AW    = 14;
  localparam int DEPTH = 4;

  logic          F14M = 1'b0;
  logic          reset, cpu_wr, cpu_rd, io_wr, vid_req, vsync;
  logic [AW-1:0] cpu_addr, vid_addr, ram_addr;
  logic [7:0]    cpu_data, io_data, cpu_rd_data, vid_data, ram_wdata, ram_rdata;
  logic [1:0]    io_addr;
  logic          cpu_wait, cpu_rd_valid, cpu_overrun, vid_valid, ram_we, irq;
  logic          gfx_en, text80;
  logic [2:0]    gfx_mode;
  logic [3:0]    fg, bg, border;

  int checks = 0;
  int errors = 0;

  vdc_cpu_port #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .F14M(F14M), .reset(reset), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .cpu_wait(cpu_wait), .cpu_rd_data(cpu_rd_data),
    .cpu_rd_valid(cpu_rd_valid), .cpu_overrun(cpu_overrun), .io_wr(io_wr), .io_addr(io_addr),
    .io_data(io_data), .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
    .vid_valid(vid_valid), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .vsync(vsync), .irq(irq), .gfx_en(gfx_en), .gfx_mode(gfx_mode),
    .text80(text80), .fg(fg), .bg(bg), .border(border)
  );

  always #5 F14M = ~F14M;

  // Synchronous VRAM seen by the DUT
  logic [7:0] ram_mem [1 << AW];
  always @(posedge F14M) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  // Reference model state
  logic [7:0]            exp_mem [1 << AW];
  logic [AW+7:0]         m_q [$];
  bit                    m_rd_pend, m_rd_now, m_vid_now, m_overrun, m_irq, m_prev_vs, m_fall_prev;
  logic [AW-1:0]         m_rd_addr;
  logic [7:0]            m_rd_data, m_vid_data;
  logic                  m_gfx_en, m_text80;
  logic [2:0]            m_gfx_mode;
  logic [3:0]            m_fg, m_bg, m_border;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rd_pend = 0; m_rd_now = 0; m_vid_now = 0; m_overrun = 0;
    m_irq = 0; m_prev_vs = 0; m_fall_prev = 0;
    m_gfx_en = 0; m_gfx_mode = 3'd5; m_text80 = 0;
    m_fg = 4'd15; m_bg = 4'd1; m_border = 4'd9;
  endtask

  // Checks the current cycle against the model, then advances the model by one cycle.
  task automatic model_cycle();
    bit            wait_e, next_vid, next_rd, fall_now;
    logic [AW+7:0] e;
    wait_e   = (m_q.size() == DEPTH) || m_rd_pend;
    next_vid = 0;
    next_rd  = 0;
    chk("cpu_wait", cpu_wait, wait_e);
    chk("cpu_rd_valid", cpu_rd_valid, m_rd_now);
    if (m_rd_now) chk("cpu_rd_data", cpu_rd_data, m_rd_data);
    chk("vid_valid", vid_valid, m_vid_now);
    if (m_vid_now) chk("vid_data", vid_data, m_vid_data);
    chk("cpu_overrun", cpu_overrun, m_overrun);
    chk("regs", {gfx_en, gfx_mode, text80, fg, bg, border},
        {m_gfx_en, m_gfx_mode, m_text80, m_fg, m_bg, m_border});
    chk("irq", irq, m_irq);
    if (vid_req) begin
      chk("vid_ram_we", ram_we, 0);
      chk("vid_ram_addr", ram_addr, vid_addr);
      next_vid   = 1;
      m_vid_data = exp_mem[vid_addr];
    end else if (m_q.size() != 0) begin
      e = m_q.pop_front();
      chk("drain_we", ram_we, 1);
      chk("drain_addr_data", {ram_addr, ram_wdata}, e);
      exp_mem[e[AW+7:8]] = e[7:0];
    end else begin
      chk("idle_ram_we", ram_we, 0);
      if (m_rd_pend) begin
        chk("rd_ram_addr", ram_addr, m_rd_addr);
        next_rd   = 1;
        m_rd_data = exp_mem[m_rd_addr];
        m_rd_pend = 0;
      end
    end
    if (cpu_wr && !wait_e) m_q.push_back({cpu_addr, cpu_data});
    if (cpu_rd && !cpu_wr && !wait_e) begin
      m_rd_pend = 1;
      m_rd_addr = cpu_addr;
    end
    if (((cpu_wr || cpu_rd) && wait_e) || (cpu_wr && cpu_rd)) m_overrun = 1;
    if (io_wr) begin
      case (io_addr)
        2'd0: begin m_gfx_en = io_data[3]; m_gfx_mode = io_data[2:0]; m_text80 = io_data[4]; end
        2'd1: begin m_fg = io_data[7:4]; m_bg = io_data[3:0]; end
        2'd2: m_border = io_data[3:0];
        default: ;
      endcase
    end
`ifdef VDC_IRQ_EN
    fall_now = m_prev_vs && !vsync;
    if (m_fall_prev) m_irq = 1;
    else if (io_wr && io_addr == 2'd3) m_irq = 0;
    m_fall_prev = fall_now;
    m_prev_vs   = vsync;
`else
    fall_now = 0;
`endif
    m_vid_now = next_vid;
    m_rd_now  = next_rd;
  endtask

  task automatic tick();
    vid_addr = AW'($urandom_range(0, 31));
    #1;
    model_cycle();
    @(posedge F14M);
    #1;
  endtask

  task automatic clear_strobes();
    cpu_wr = 0; cpu_rd = 0; io_wr = 0; vid_req = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_strobes();
    #1;
    chk("reset_rd_valid", cpu_rd_valid, 0);
    chk("reset_vid_valid", vid_valid, 0);
    chk("reset_ram_we", ram_we, 0);
    @(posedge F14M); #1;
    @(posedge F14M); #1;
    model_reset();
    reset = 0;
  endtask

  initial begin
    bit got, wr_seen;
    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i] = 8'(i) ^ 8'h5A;
      exp_mem[i] = 8'(i) ^ 8'h5A;
    end
    reset = 1; vsync = 1; cpu_addr = '0; cpu_data = '0; io_addr = '0; io_data = '0;
    vid_addr = '0;
    clear_strobes();
    @(posedge F14M); #1;
    do_reset();

    // Reset values
    #1;
    chk("rst_gfx_mode", gfx_mode, 5);
    chk("rst_fg", fg, 15);
    chk("rst_bg", bg, 1);
    chk("rst_border", border, 9);
    chk("rst_gfx_en_text80", {gfx_en, text80}, 0);
    chk("rst_cpu_wait", cpu_wait, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rd", {cpu_rd_valid, cpu_rd_data, cpu_overrun}, 0);
    chk("rst_vid", {vid_valid, vid_data}, 0);
    chk("rst_ram", {ram_we, ram_addr}, 0);
    tick();

    // Single posted write reaches RAM one cycle later
    cpu_wr = 1; cpu_addr = 14'h3800; cpu_data = 8'h41;
    tick();
    cpu_wr = 0;
    #1;
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, 14'h3800);
    chk("wr_ram_wdata", ram_wdata, 8'h41);
    tick();

    // FIFO fills under video contention; fifth write is dropped
    vid_req = 1;
    for (int i = 0; i < 5; i++) begin
      cpu_wr = 1; cpu_addr = AW'(14'h0100 + i); cpu_data = 8'(8'h10 + i);
      if (i == 4) begin #1; chk("full_cpu_wait", cpu_wait, 1); end
      tick();
    end
    cpu_wr = 0;
    #1;
    chk("full_overrun", cpu_overrun, 1);
    vid_req = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_order_addr", ram_addr, 14'h0100 + i);
      chk("drain_order_data", ram_wdata, 8'h10 + i);
      if (i == 0) chk("drain_wait_full", cpu_wait, 1);
      tick();
    end
    #1;
    chk("drain_wait_low", cpu_wait, 0);
    chk("drain_done_we", ram_we, 0);
    tick();

    // Read-after-write with interleaved video fetches
    do_reset();
    cpu_wr = 1; cpu_addr = 14'h0010; cpu_data = 8'hAA;
    tick();
    cpu_wr = 0; cpu_rd = 1;
    got = 0; wr_seen = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      vid_req = c[0];
      #1;
      if (ram_we && ram_addr == 14'h0010) wr_seen = 1;
      if (cpu_rd_valid) begin
        got = 1;
        chk("raw_order", wr_seen, 1);
        chk("raw_data", cpu_rd_data, 8'hAA);
      end
      tick();
      cpu_rd = 0;
    end
    chk("raw_rd_valid_seen", got, 1);
    vid_req = 0;
    tick();

    // VDC registers
    io_wr = 1; io_addr = 2'd0; io_data = 8'h1D;
    tick();
    io_addr = 2'd1; io_data = 8'h2C;
    tick();
    io_wr = 0;
    #1;
    chk("io_mode", {gfx_en, gfx_mode, text80}, {1'b1, 3'd5, 1'b1});
    chk("io_colour", {fg, bg}, 8'h2C);
    tick();

    // Vertical-blank interrupt
    vsync = 1;
    repeat (3) tick();
    vsync = 0;
    tick();
    #1; chk("irq_t1", irq, 0);
    tick();
`ifdef VDC_IRQ_EN
    #1; chk("irq_set", irq, 1);
`else
    #1; chk("irq_tied", irq, 0);
`endif
    io_wr = 1; io_addr = 2'd3; io_data = 8'h00;
    tick();
    io_wr = 0; vsync = 1;
    #1; chk("irq_ack", irq, 0);
    tick();

    // Reset while a read is held off by video
    vid_req = 1; cpu_rd = 1; cpu_addr = 14'h0005;
    tick();
    cpu_rd = 0;
    tick();
    #1; chk("pend_wait", cpu_wait, 1);
    do_reset();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("post_rst_rd_valid", cpu_rd_valid, 0);
      chk("post_rst_wait", cpu_wait, 0);
      tick();
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      cpu_wr   = ($urandom_range(0, 3) == 0);
      cpu_rd   = ($urandom_range(0, 5) == 0);
      cpu_addr = AW'($urandom_range(0, 15));
      cpu_data = 8'($urandom);
      vid_req  = ($urandom_range(0, 2) == 0);
      io_wr    = ($urandom_range(0, 7) == 0);
      io_addr  = 2'($urandom);
      io_data  = 8'($urandom);
      if ($urandom_range(0, 9) == 0) vsync = ~vsync;
      tick();
    end
    clear_strobes();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
